// File: rtl/uart_led_cmd_rx.sv
// UART 8N1 receiver with a two-byte "L<hex>" command parser that drives the
// keyboard-LED update interface of the HID host.
module uart_led_cmd_rx #(
  parameter int unsigned CLK_FREQ = 12000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       usbclk,
  input  logic       usbrst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       cmd_err,
  output logic [3:0] leds,
  output logic       update_leds_stb
);

  localparam int unsigned DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] DivLast  = CW'(DIV - 1);
  localparam logic [CW-1:0] HalfLast = CW'(DIV / 2 - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  localparam logic PCmd = 1'b0;
  localparam logic PArg = 1'b1;

  logic          sync1_q, sync2_q;
  logic [2:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          p_st_q, p_st_d;
  logic [3:0]    leds_q, leds_d;
  logic          stb_q, stb_d;
  logic          cmd_err_q, cmd_err_d;
  logic          line;
  logic          is_hex;
  logic [3:0]    hex_val;

  assign line = sync2_q;

  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_st_q     <= StIdle;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      p_st_q      <= PCmd;
      leds_q      <= '0;
      stb_q       <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      sync1_q     <= uart_rx;
      sync2_q     <= sync1_q;
      rx_st_q     <= rx_st_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      p_st_q      <= p_st_d;
      leds_q      <= leds_d;
      stb_q       <= stb_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  always_comb begin
    rx_st_d     = rx_st_q;
    baud_d      = baud_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_st_q)
      StIdle: begin
        baud_d = '0;
        bit_d  = '0;
        if (!line) rx_st_d = StStart;
      end
      StStart: begin
        if (baud_q == HalfLast) begin
          baud_d  = '0;
          rx_st_d = line ? StIdle : StData;
        end
      end
      StData: begin
        if (baud_q == DivLast) begin
          baud_d  = '0;
          shift_d = {line, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = StStop;
        end
      end
      StStop: begin
        if (baud_q == DivLast) begin
          baud_d = '0;
          if (line) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            rx_st_d    = StIdle;
          end else begin
            frame_err_d = 1'b1;
            rx_st_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // A held-low line must produce only the single frame_err already issued.
        baud_d = '0;
        if (line) rx_st_d = StIdle;
      end
      default: rx_st_d = StIdle;
    endcase
  end

  always_comb begin
    is_hex  = 1'b0;
    hex_val = rx_data_q[3:0];
    if (rx_data_q >= 8'h30 && rx_data_q <= 8'h39) begin
      is_hex = 1'b1;
    end else if ((rx_data_q >= 8'h41 && rx_data_q <= 8'h46) ||
                 (rx_data_q >= 8'h61 && rx_data_q <= 8'h66)) begin
      is_hex  = 1'b1;
      hex_val = rx_data_q[3:0] + 4'd9;
    end
  end

  always_comb begin
    p_st_d    = p_st_q;
    leds_d    = leds_q;
    stb_d     = 1'b0;
    cmd_err_d = 1'b0;
    if (frame_err_q) begin
      p_st_d = PCmd;
    end else if (rx_valid_q) begin
      if (p_st_q == PCmd) begin
        if (rx_data_q == 8'h4C || rx_data_q == 8'h6C) begin
          p_st_d = PArg;
        end else if (rx_data_q != 8'h0D && rx_data_q != 8'h0A && rx_data_q != 8'h20) begin
          cmd_err_d = 1'b1;
        end
      end else begin
        p_st_d = PCmd;
        if (is_hex) begin
          leds_d = hex_val;
          stb_d  = 1'b1;
        end else begin
          cmd_err_d = 1'b1;
        end
      end
    end
  end

  assign rx_data         = rx_data_q;
  assign rx_valid        = rx_valid_q;
  assign frame_err       = frame_err_q;
  assign cmd_err         = cmd_err_q;
  assign leds            = leds_q;
  assign update_leds_stb = stb_q;

endmodule

// File: tb/tb_uart_led_cmd_rx.sv
// Bench for uart_led_cmd_rx: byte-level reference model schedules expected pulses
// per cycle; a negedge process compares every output on every cycle.
module tb_uart_led_cmd_rx;

  localparam int DIV = 104;
  // Drive cycle of start bit to the cycle rx_valid/frame_err is visible.
  localparam int LAT = 3 + DIV / 2 + 9 * DIV;

  logic       usbclk = 1'b0;
  logic       usbrst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, cmd_err, update_leds_stb;
  logic [3:0] leds;

  uart_led_cmd_rx dut (
    .usbclk          (usbclk),
    .usbrst_n        (usbrst_n),
    .uart_rx         (uart_rx),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .frame_err       (frame_err),
    .cmd_err         (cmd_err),
    .leds            (leds),
    .update_leds_stb (update_leds_stb)
  );

  always #5 usbclk = ~usbclk;

  int cyc = 0;
  always @(posedge usbclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  int n_valid = 0, n_ferr = 0, n_cerr = 0, n_stb = 0;

  // Reference model: expected events keyed by cycle number.
  logic [7:0] ev_valid  [int];
  logic [3:0] ev_strobe [int];
  bit         ev_ferr   [int];
  bit         ev_cerr   [int];
  bit         m_arg = 1'b0;
  logic [7:0] exp_rx = 8'h00;
  logic [3:0] exp_leds = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit hex_of(input logic [7:0] b, output logic [3:0] v);
    int x;
    x = -1;
    if (b >= "0" && b <= "9") x = int'(b) - int'("0");
    else if (b >= "A" && b <= "F") x = int'(b) - int'("A") + 10;
    else if (b >= "a" && b <= "f") x = int'(b) - int'("a") + 10;
    v = 4'(x);
    return x >= 0;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit good, input int v);
    logic [3:0] hv;
    if (!good) begin
      ev_ferr[v] = 1'b1;
      m_arg = 1'b0;
    end else begin
      ev_valid[v] = b;
      if (m_arg) begin
        m_arg = 1'b0;
        if (hex_of(b, hv)) ev_strobe[v + 1] = hv;
        else ev_cerr[v + 1] = 1'b1;
      end else if (b == "L" || b == "l") begin
        m_arg = 1'b1;
      end else if (b != 8'h0D && b != 8'h0A && b != 8'h20) begin
        ev_cerr[v + 1] = 1'b1;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge usbclk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good_stop);
    model_byte(b, good_stop, cyc + LAT);
    uart_rx = 1'b0;
    tick(DIV);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      tick(DIV);
    end
    uart_rx = good_stop;
    tick(DIV);
  endtask

  task automatic do_reset(input int n);
    usbrst_n = 1'b0;
    uart_rx  = 1'b1;
    ev_valid.delete();
    ev_strobe.delete();
    ev_ferr.delete();
    ev_cerr.delete();
    m_arg = 1'b0;
    tick(n);
  endtask

  always @(negedge usbclk) begin : cmp
    logic e_valid, e_stb, e_ferr, e_cerr;
    e_valid = 1'b0; e_stb = 1'b0; e_ferr = 1'b0; e_cerr = 1'b0;
    if (!usbrst_n) begin
      exp_rx   = 8'h00;
      exp_leds = 4'h0;
    end else begin
      e_valid = ev_valid.exists(cyc);
      if (e_valid) exp_rx = ev_valid[cyc];
      e_stb = ev_strobe.exists(cyc);
      if (e_stb) exp_leds = ev_strobe[cyc];
      e_ferr = ev_ferr.exists(cyc);
      e_cerr = ev_cerr.exists(cyc);
    end
    check("rx_data", 32'(rx_data), 32'(exp_rx));
    check("rx_valid", 32'(rx_valid), 32'(e_valid));
    check("frame_err", 32'(frame_err), 32'(e_ferr));
    check("cmd_err", 32'(cmd_err), 32'(e_cerr));
    check("leds", 32'(leds), 32'(exp_leds));
    check("update_leds_stb", 32'(update_leds_stb), 32'(e_stb));
    n_valid += int'(rx_valid);
    n_ferr  += int'(frame_err);
    n_cerr  += int'(cmd_err);
    n_stb   += int'(update_leds_stb);
  end

  initial begin
    int s_valid, s_ferr, s_cerr, s_stb;
    string hexch;
    hexch = "0123456789ABCDEFabcdef";

    do_reset(5);
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    usbrst_n = 1'b1;
    tick(10);

    // 'L' '5'
    s_valid = n_valid; s_stb = n_stb;
    send_frame("L", 1'b1);
    check("t1_rx_L", 32'(rx_data), 32'h4C);
    send_frame("5", 1'b1);
    check("t1_rx_5", 32'(rx_data), 32'h35);
    check("t1_leds", 32'(leds), 32'b0101);
    check("t1_valid_cnt", 32'(n_valid - s_valid), 32'd2);
    check("t1_stb_cnt", 32'(n_stb - s_stb), 32'd1);

    // 'l' 'a' back-to-back
    s_stb = n_stb; s_cerr = n_cerr; s_ferr = n_ferr;
    send_frame("l", 1'b1);
    send_frame("a", 1'b1);
    check("t2_leds", 32'(leds), 32'b1010);
    check("t2_stb_cnt", 32'(n_stb - s_stb), 32'd1);
    check("t2_err_cnt", 32'((n_cerr - s_cerr) + (n_ferr - s_ferr)), 32'd0);

    // 'X' then 'L' 'Z'
    s_stb = n_stb; s_cerr = n_cerr;
    tick(3 * DIV);
    send_frame("X", 1'b1);
    send_frame("L", 1'b1);
    send_frame("Z", 1'b1);
    check("t3_cerr_cnt", 32'(n_cerr - s_cerr), 32'd2);
    check("t3_leds", 32'(leds), 32'b1010);
    check("t3_stb_cnt", 32'(n_stb - s_stb), 32'd0);

    // Short low glitch, then 0x41
    s_valid = n_valid; s_ferr = n_ferr;
    uart_rx = 1'b0;
    tick(20);
    uart_rx = 1'b1;
    tick(2 * DIV);
    check("t4_glitch_valid", 32'(n_valid - s_valid), 32'd0);
    check("t4_glitch_ferr", 32'(n_ferr - s_ferr), 32'd0);
    send_frame(8'h41, 1'b1);
    check("t4_rx_41", 32'(rx_data), 32'h41);
    check("t4_valid_cnt", 32'(n_valid - s_valid), 32'd1);

    // Bad stop bit held low, then '3'
    s_ferr = n_ferr; s_cerr = n_cerr;
    send_frame("L", 1'b0);
    tick(3000);
    uart_rx = 1'b1;
    tick(DIV);
    send_frame("3", 1'b1);
    check("t5_ferr_cnt", 32'(n_ferr - s_ferr), 32'd1);
    check("t5_cerr_cnt", 32'(n_cerr - s_cerr), 32'd1);
    check("t5_leds", 32'(leds), 32'b1010);
    tick(DIV);

    // Frame error after a good 'L' aborts the argument
    s_cerr = n_cerr; s_stb = n_stb;
    send_frame("L", 1'b1);
    send_frame("5", 1'b0);
    tick(50);
    uart_rx = 1'b1;
    tick(DIV);
    send_frame("5", 1'b1);
    check("t5b_cerr_cnt", 32'(n_cerr - s_cerr), 32'd1);
    check("t5b_stb_cnt", 32'(n_stb - s_stb), 32'd0);
    check("t5b_rx_data", 32'(rx_data), 32'h35);

    // 'L' 'F', then reset mid-frame
    send_frame("L", 1'b1);
    send_frame("F", 1'b1);
    check("t6_leds_F", 32'(leds), 32'hF);
    uart_rx = 1'b0;
    tick(DIV);
    for (int k = 0; k < 3; k++) begin
      uart_rx = k[0];
      tick(DIV);
    end
    tick(DIV / 2);
    do_reset(3);
    check("t6_leds_in_reset", 32'(leds), 32'h0);
    usbrst_n = 1'b1;
    tick(DIV);
    s_stb = n_stb;
    send_frame("L", 1'b1);
    send_frame("7", 1'b1);
    check("t6_leds_7", 32'(leds), 32'b0111);
    check("t6_stb_cnt", 32'(n_stb - s_stb), 32'd1);

    // Randomized command stream
    for (int i = 0; i < 30; i++) begin
      int kind;
      logic [7:0] b;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2: b = ($urandom_range(0, 1) != 0) ? 8'h4C : 8'h6C;
        3, 4, 5: b = hexch[$urandom_range(0, 21)];
        6: b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h20;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if (kind == 8) begin
        send_frame(b, 1'b0);
        tick($urandom_range(0, 300));
        uart_rx = 1'b1;
        tick(DIV);
      end else begin
        send_frame(b, 1'b1);
        tick($urandom_range(0, 2 * DIV));
      end
    end

    tick(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
